// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and defaults for the 16-bit CPU front end.
//   fetch_state_t : fetch FSM states (HALT only when FETCH_TIMEOUT_EN is defined)
//   DEF_ADDR_W    : default instruction address / PC width
//   DEF_RESET_PC  : default fetch address after reset
//   INSTR_W       : instruction word width
package cpu_pkg;
  localparam int          DEF_ADDR_W   = 16;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;
  localparam int          INSTR_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HOLD
`ifdef FETCH_TIMEOUT_EN
    , HALT
`endif
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory read bus.
//   mem_req/mem_addr : request from fetch (master)
//   mem_ack/mem_rdata: completion from memory (slave); rdata valid with ack
interface fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: fetch program counter plus saved redirect target.
//   clk, reset   : clock, async active-high reset (both regs -> RESET_PC)
//   ld, ld_val   : load fetch_pc (wins over inc)
//   inc          : advance fetch_pc by one, wrapping at 2^ADDR_W
//   sv, sv_val   : capture a redirect target for later use
//   fetch_pc     : current fetch address
//   tgt_pc       : saved redirect target
module fetch_pc_reg #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic [ADDR_W-1:0] ld_val,
  input  logic              inc,
  input  logic              sv,
  input  logic [ADDR_W-1:0] sv_val,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic [ADDR_W-1:0] tgt_pc
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      tgt_pc   <= RESET_PC;
    end else begin
      if (ld)       fetch_pc <= ld_val;
      else if (inc) fetch_pc <= fetch_pc + ADDR_W'(1);  // natural wrap
      if (sv)       tgt_pc   <= sv_val;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the instruction register.
//   clk, reset          : clock, async active-high reset
//   stall               : decode not ready; holds off new requests
//   redirect/redirect_pc: taken branch/jump pulse and its target
//   mem (master)        : instruction memory req/ack bus
//   ir_data/ir_we       : IR data input and one-cycle write strobe
//   pc                  : address of the word on ir_data
//   fetch_err           : sticky ack timeout (only with FETCH_TIMEOUT_EN,
//                         otherwise tied low)
// Optional feature macro: FETCH_TIMEOUT_EN (ack-wait watchdog + HALT state).
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W         = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC       = ADDR_W'(DEF_RESET_PC),
  parameter int                TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  fetch_unit_if.master       mem,
  output logic [INSTR_W-1:0] ir_data,
  output logic               ir_we,
  output logic [ADDR_W-1:0]  pc,
  output logic               fetch_err
);
  // The wait counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("fetch_unit: TIMEOUT_CYCLES must be 1..255");
  end

  fetch_state_t      state, nxt;
  logic              ld, inc, sv, accept, req;
  logic [ADDR_W-1:0] ld_val, fetch_pc, tgt_pc;

  fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .reset(reset),
    .ld(ld), .ld_val(ld_val), .inc(inc),
    .sv(sv), .sv_val(redirect_pc),
    .fetch_pc(fetch_pc), .tgt_pc(tgt_pc)
  );

  // Address only moves on ack or outside a request, so it is stable while waiting.
  assign mem.mem_req  = req;
  assign mem.mem_addr = fetch_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
`endif

  always_comb begin
    nxt    = state;
    ld     = 1'b0;
    ld_val = redirect_pc;
    inc    = 1'b0;
    sv     = 1'b0;
    accept = 1'b0;
    req    = 1'b0;
    case (state)
      IDLE: begin
        ld  = redirect;
        nxt = stall ? HOLD : ISSUE;
      end
      ISSUE: begin
        req = 1'b1;
        if (mem.mem_ack) begin
          // A coinciding redirect kills the returning word.
          ld     = redirect;
          inc    = !redirect;
          accept = !redirect;
          nxt    = stall ? HOLD : ISSUE;
        end else if (redirect) begin
          sv  = 1'b1;
          nxt = DRAIN;
        end
      end
      DRAIN: begin
        req = 1'b1;
        if (mem.mem_ack) begin
          // A redirect arriving with the ack is newer than the saved target.
          ld     = 1'b1;
          ld_val = redirect ? redirect_pc : tgt_pc;
          nxt    = stall ? HOLD : ISSUE;
        end else begin
          sv = redirect;
        end
      end
      HOLD: begin
        ld = redirect;
        if (!stall) nxt = ISSUE;
      end
`ifdef FETCH_TIMEOUT_EN
      HALT: nxt = HALT;
`endif
      default: nxt = IDLE;
    endcase
`ifdef FETCH_TIMEOUT_EN
    if (req && !mem.mem_ack && wait_cnt == TO_LIM) nxt = HALT;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ir_data <= '0;
      ir_we   <= 1'b0;
      pc      <= RESET_PC;
    end else begin
      state <= nxt;
      ir_we <= accept;
      if (accept) begin
        ir_data <= mem.mem_rdata;
        pc      <= fetch_pc;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      wait_cnt  <= (req && !mem.mem_ack) ? wait_cnt + 8'd1 : 8'd0;
      fetch_err <= fetch_err | (nxt == HALT);
    end
  end
`else
  assign fetch_err = 1'b0;
`endif
endmodule
